// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter: state encoding, fill
// destination codes and line-offset width helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_t;

    localparam logic DST_I = 1'b0;
    localparam logic DST_D = 1'b1;

    // Byte-offset bits covered by one line of 16-bit words.
    function automatic int offset_w(input int block_words);
        return $clog2(block_words) + 1;
    endfunction

    localparam int OFFSET_W = offset_w(8);

endpackage

// File: rtl/mem_fill_ctr.sv
// Issue and receive word counters for one line fill; start restarts both
// counters and opens a BLOCK_WORDS-long issue window.
module mem_fill_ctr #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           mem_rdata_valid,
    output logic                           issue_en,
    output logic [$clog2(BLOCK_WORDS)-1:0] issue_idx,
    output logic [$clog2(BLOCK_WORDS)-1:0] recv_idx,
    output logic                           last_recv
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    logic issuing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issuing   <= 1'b0;
            issue_idx <= '0;
            recv_idx  <= '0;
        end else begin
            if (start) begin
                issuing   <= 1'b1;
                issue_idx <= '0;
            end else if (issuing) begin
                issue_idx <= issue_idx + 1'b1;
                if (issue_idx == LAST_IDX)
                    issuing <= 1'b0;
            end

            if (start)
                recv_idx <= '0;
            else if (mem_rdata_valid)
                recv_idx <= recv_idx + 1'b1;
        end
    end

    assign issue_en  = issuing;
    assign last_recv = mem_rdata_valid && (recv_idx == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between the I-cache fill path and the D-cache
// fill/write-through path, sequencing line fills and steering returned words.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int LATENCY     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_rdata_valid,
    output logic                           fill_valid,
    output logic                           fill_dst,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]              fill_data,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);

    localparam int OFF_W = offset_w(BLOCK_WORDS);
    localparam int IDX_W = OFF_W - 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

    // The arbiter itself only trusts mem_rdata_valid; LATENCY just has to be sane.
    if (LATENCY < 1 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_param_check
        $error("mem_arbiter: LATENCY must be >= 1 and BLOCK_WORDS a power of 2");
    end

    arb_state_t state, state_next;

    logic              last_d;
    logic              grant_i;
    logic              grant_d;
    logic              start_fill;
    logic              in_fill;
    logic              fill_rvalid;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    logic              issue_en;
    logic [IDX_W-1:0]  issue_idx;
    logic [IDX_W-1:0]  recv_idx;
    logic              last_recv;

    assign in_fill     = (state == I_FILL) || (state == D_FILL);
    assign fill_rvalid = in_fill && mem_rdata_valid;
    assign fill_data   = mem_rdata;
    assign busy        = (state != IDLE);

    // D normally wins a tie; after a D completion the next tie goes to I.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (d_req && (!i_req || !last_d))
                grant_d = 1'b1;
            else if (i_req)
                grant_i = 1'b1;
        end
    end

    assign start_fill = grant_i || (grant_d && !d_wr);

    mem_fill_ctr #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_fill_ctr (
        .clk             (clk),
        .rst             (rst),
        .start           (start_fill),
        .mem_rdata_valid (fill_rvalid),
        .issue_en        (issue_en),
        .issue_idx       (issue_idx),
        .recv_idx        (recv_idx),
        .last_recv       (last_recv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_next;
            if (d_done)
                last_d <= 1'b1;
            else if (i_done)
                last_d <= 1'b0;
        end
    end

    // Fill requests keep only the line base so the word offset can be OR-ed in.
    always_ff @(posedge clk) begin
        if (grant_d) begin
            cap_addr <= d_wr ? d_addr : (d_addr & BASE_MASK);
            cap_data <= d_wdata;
        end else if (grant_i) begin
            cap_addr <= i_addr & BASE_MASK;
        end
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_dst   = DST_I;
        fill_idx   = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        case (state)
            IDLE: begin
                if (grant_d)
                    state_next = d_wr ? D_WRITE : D_FILL;
                else if (grant_i)
                    state_next = I_FILL;
            end

            I_FILL, D_FILL: begin
                if (issue_en) begin
                    mem_en   = 1'b1;
                    mem_addr = cap_addr | ADDR_W'({issue_idx, 1'b0});
                end
                if (mem_rdata_valid) begin
                    fill_valid = 1'b1;
                    fill_dst   = (state == D_FILL) ? DST_D : DST_I;
                    fill_idx   = recv_idx;
                end
                if (last_recv) begin
                    if (state == D_FILL)
                        d_done = 1'b1;
                    else
                        i_done = 1'b1;
                    state_next = IDLE;
                end
            end

            D_WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = cap_addr;
                mem_wdata  = cap_data;
                d_done     = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a fill-beat
// scoreboard filled when requests are raised and drained on fill_valid.
module tb_mem_arbiter;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int LATENCY     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              d_req = 1'b0;
    logic              d_wr = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rdata_valid = 1'b0;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              fill_valid;
    logic              fill_dst;
    logic [2:0]        fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              i_done;
    logic              d_done;
    logic              busy;

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BLOCK_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .d_req           (d_req),
        .d_wr            (d_wr),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .mem_en          (mem_en),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .fill_valid      (fill_valid),
        .fill_dst        (fill_dst),
        .fill_idx        (fill_idx),
        .fill_data       (fill_data),
        .i_done          (i_done),
        .d_done          (d_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dst;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        int          ready;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int i_done_cnt = 0;
    int d_done_cnt = 0;
    int stray = 0;
    bit gap = 1'b0;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_fill(input logic dst, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < BLOCK_WORDS; k++)
            exp_q.push_back('{dst, 3'(k), mdata(base | 16'(k << 1)), (k == BLOCK_WORDS - 1)});
    endtask

    // One clock: memory drives just after the edge, checks run on the falling edge.
    task automatic cycle();
        mreq_t m;
        exp_t  e;
        @(posedge clk);
        cyc++;
        #1;
        mem_rdata_valid = 1'b0;
        if (stray > 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = 16'hDEAD;
            stray--;
        end else if (mem_q.size() > 0 && mem_q[0].ready <= cyc && !(gap && (cyc % 3 == 1))) begin
            m = mem_q.pop_front();
            mem_rdata_valid = 1'b1;
            mem_rdata = mdata(m.addr);
        end
        @(negedge clk);
        if (mem_en === 1'b1 && mem_wr === 1'b0)
            mem_q.push_back('{mem_addr, cyc + LATENCY});
        if (fill_valid === 1'b1) begin
            fv_cnt++;
            chk("fill_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fill_dst", fill_dst, e.dst);
                chk("fill_idx", fill_idx, e.idx);
                chk("fill_data", fill_data, e.data);
                chk("i_done_on_beat", i_done, e.last && !e.dst);
                chk("d_done_on_beat", d_done, e.last && e.dst);
            end
        end
        if (i_done === 1'b1) begin
            i_done_cnt++;
            chk("i_done_with_fill", fill_valid, 1);
            chk("done_exclusive", d_done, 0);
        end
        if (d_done === 1'b1)
            d_done_cnt++;
    endtask

    task automatic wait_done(input bit want_d, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            cycle();
            seen = want_d ? (d_done === 1'b1) : (i_done === 1'b1);
        end
        chk({tag, "_done"}, seen, 1);
    endtask

    initial begin
        int n;
        int f0;
        int idone0;

        // Reset state
        cycle();
        cycle();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_dst", fill_dst, 0);
        chk("rst_fill_idx", fill_idx, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        cycle();

        // I fill from 0x1236, checked cycle by cycle
        i_req = 1'b1;
        i_addr = 16'h1236;
        push_fill(1'b0, 16'h1236);
        chk("t1_idle_mem_en", mem_en, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            chk("t1_mem_en", mem_en, (k <= 8));
            if (k <= 8)
                chk("t1_mem_addr", mem_addr, 16'h1230 + 2 * (k - 1));
            chk("t1_fill_valid", fill_valid, (k >= 5));
            chk("t1_i_done", i_done, (k == 12));
        end
        i_req = 1'b0;
        cycle();
        chk("t1_busy_after", busy, 0);

        // D single-word write
        d_req = 1'b1;
        d_wr = 1'b1;
        d_addr = 16'h0044;
        d_wdata = 16'hBEEF;
        chk("t2_idle_mem_en", mem_en, 0);
        cycle();
        chk("t2_mem_en", mem_en, 1);
        chk("t2_mem_wr", mem_wr, 1);
        chk("t2_mem_addr", mem_addr, 16'h0044);
        chk("t2_mem_wdata", mem_wdata, 16'hBEEF);
        chk("t2_d_done", d_done, 1);
        d_req = 1'b0;
        d_wr = 1'b0;
        cycle();
        chk("t2_busy_after", busy, 0);
        chk("t2_mem_en_after", mem_en, 0);
        chk("t2_d_done_after", d_done, 0);

        // Simultaneous requests from reset, then a tie while last_d is set
        rst = 1'b1;
        #1;
        rst = 1'b0;
        cycle();
        i_req = 1'b1;
        i_addr = 16'h2000;
        d_req = 1'b1;
        d_addr = 16'h3458;
        push_fill(1'b1, 16'h3458);
        push_fill(1'b0, 16'h2000);
        wait_done(1'b1, 40, "t3_d_first");
        d_addr = 16'h3460;
        push_fill(1'b1, 16'h3460);
        cycle();
        chk("t3_idle_gap_busy", busy, 0);
        wait_done(1'b0, 40, "t3_i_second");
        i_req = 1'b0;
        wait_done(1'b1, 40, "t3_d_third");
        d_req = 1'b0;
        cycle();

        // Fill with gaps in the memory return stream
        gap = 1'b1;
        i_req = 1'b1;
        i_addr = 16'hABCE;
        push_fill(1'b0, 16'hABCE);
        f0 = fv_cnt;
        wait_done(1'b0, 80, "t4_gapped");
        chk("t4_valid_count", fv_cnt - f0, 8);
        i_req = 1'b0;
        gap = 1'b0;
        cycle();

        // Asynchronous reset at the third fill beat, then stray returns
        i_req = 1'b1;
        i_addr = 16'h5550;
        push_fill(1'b0, 16'h5550);
        idone0 = i_done_cnt;
        n = 0;
        for (int b = 0; b < 40 && n < 3; b++) begin
            cycle();
            if (fill_valid === 1'b1)
                n++;
        end
        chk("t5_third_beat", n, 3);
        #1;
        rst = 1'b1;
        i_req = 1'b0;
        #1;
        chk("t5_rst_fill_valid", fill_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_mem_en", mem_en, 0);
        exp_q.delete();
        mem_q.delete();
        stray = 3;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t5_stray_fill_valid", fill_valid, 0);
            chk("t5_stray_busy", busy, 0);
        end
        chk("t5_no_i_done", i_done_cnt, idone0);

        // Spurious returns while idle
        stray = 4;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t6_fill_valid", fill_valid, 0);
            chk("t6_done", {i_done, d_done}, 0);
            chk("t6_busy", busy, 0);
        end

        chk("sb_empty", exp_q.size(), 0);
        chk("i_done_total", i_done_cnt, 3);
        chk("d_done_total", d_done_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
